apb_slave_mux: RTL
==================

# apb_slave_mux

Parametrised APB fan-out block that connects one APB master to `NUM_SLAVES` slave devices. It decodes the address into a slave select, tracks the SETUP/ACCESS phase, and routes the selected slave's response back to the master. It adds features the plain bus bundle lacks: a decode-error response for unmapped addresses, a wait-state timeout that forces PSLVERR, and a sticky protocol-violation flag. It sits between the testbench/SoC master and the slave peripherals. Strobe, protection and slave-error signals are always present; compile-time defines no longer gate them.

## Interface
- `ADDR_WIDTH`, 32, address bus width
- `DATA_WIDTH`, 32, data bus width (8, 16 or 32)
- `NUM_SLAVES`, 4, slave count, 1..16
- `REGION_LSB`, 12, log2 of the per-slave region size; slave index = `m_addr[REGION_LSB +: IDX_W]`
- `TIMEOUT`, 16, ACCESS cycles without ready before a forced error, ≥2
- `clk` in 1: bus clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `m_sel`, `m_enable`, `m_write` in 1: master PSEL, PENABLE, PWRITE.
- `m_addr` in ADDR_WIDTH: master address.
- `m_wdata` in DATA_WIDTH: master write data.
- `m_strb` in DATA_WIDTH/8: master write strobes.
- `m_prot` in 3: master protection bits.
- `m_rdata` out DATA_WIDTH: read data returned to the master.
- `m_ready` out 1: PREADY to the master.
- `m_slverr` out 1: PSLVERR to the master.
- `s_sel` out NUM_SLAVES: one-hot slave selects.
- `s_enable`, `s_write` out 1: broadcast to all slaves.
- `s_addr`, `s_wdata`, `s_strb`, `s_prot` out: broadcast, same widths as the master side.
- `s_rdata` in NUM_SLAVES*DATA_WIDTH: packed slave read data; slave i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `s_ready`, `s_slverr` in NUM_SLAVES: per-slave PREADY and PSLVERR.
- `proto_err` out 1: sticky protocol-violation flag.

## Operation
- `IDX_W = max(1, $clog2(NUM_SLAVES))`.
- An address is mapped when `m_addr[ADDR_WIDTH-1:REGION_LSB+IDX_W] == 0` and index < NUM_SLAVES. Otherwise it is unmapped.
- FSM states: IDLE, SETUP, ACCESS, DECERR.
  - IDLE → SETUP on `m_sel & !m_enable`.
  - SETUP latches the decoded index and the mapped flag.
    - On `m_enable`: → ACCESS if mapped, → DECERR if unmapped.
  - ACCESS: `s_sel[idx]=1`, `s_enable=1`.
    - On `s_ready[idx]`: transfer completes.
    - On timeout count reaching TIMEOUT-1 without ready: transfer completes with error.
  - DECERR: no `s_sel` asserted. Completes in its first cycle with `m_ready=1`, `m_slverr=1`, `m_rdata=0`.
  - On completion: → SETUP if `m_sel & !m_enable` (back-to-back transfer), else → IDLE.
- `s_sel` follows the decoded index during SETUP and ACCESS only. All other `s_*` outputs are combinational copies of the `m_*` inputs.
- `m_rdata`:
  - `s_rdata` slice of the latched index in ACCESS.
  - Zero in all other states.
- `m_ready`, `m_slverr` are combinational:
  - ACCESS: `s_ready[idx] | tmo` and `(s_slverr[idx] & s_ready[idx]) | tmo`.
  - DECERR: both 1.
  - All other states: both 0.
- Timeout counter: cleared on entry to ACCESS, increments each ACCESS cycle. `tmo = (cnt == TIMEOUT-1) & !s_ready[idx]`.
- `proto_err` is set, and held until reset, when any of these occur:
  - `m_enable` without `m_sel`;
  - `m_enable` high in IDLE;
  - `m_addr`, `m_write` or `m_wdata` changing between SETUP and ACCESS, or during ACCESS;
  - `m_sel` dropping in ACCESS before completion. In this case the FSM also aborts to IDLE with no response.
- Reset mid-transfer: all state clears immediately and `s_sel` drops asynchronously.

## Timing
- Reset values: `m_ready=0`, `m_slverr=0`, `m_rdata=0`, `s_sel=0`, `s_enable=0`, `proto_err=0`, FSM=IDLE, `cnt=0`. The broadcast outputs mirror their inputs.
- Added latency is zero: slave ready and data reach the master in the same cycle.
- A zero-wait-state transfer takes exactly 2 cycles (SETUP, ACCESS).
- A timeout completes in the TIMEOUT-th ACCESS cycle. `s_sel` drops on the next edge.
- A decode error always takes 2 cycles (SETUP, DECERR).
- If ready and the timeout coincide, ready wins: `m_slverr = s_slverr[idx]`.

## Structure
- Shared package `apb_pkg`:
  - `apb_state_e` enum for the FSM states;
  - `APB_PROT_W = 3`;
  - an `idx_width(n)` function.
- Sub-module `apb_addr_decoder`, combinational (address → index and mapped flag). Everything else lives in `apb_slave_mux`.

## Test plan
- Write 0xA5A5_0001 to 0x0000_1004 with `s_ready[1]=1` immediately → `s_sel=4'b0010` in SETUP and ACCESS; completes in 2 cycles with `m_slverr=0`.
- Read 0x0000_3000 while slave 3 holds ready low for 3 cycles and presents rdata 0x1234_5678 → `m_ready` rises in the 4th ACCESS cycle with `m_rdata=0x1234_5678`.
- Access 0x0001_0000 (unmapped) → no `s_sel`; DECERR cycle gives `m_ready=1`, `m_slverr=1`, `m_rdata=0`.
- Slave 2 never asserts ready, TIMEOUT=16 → `m_ready=1`, `m_slverr=1` in the 16th ACCESS cycle; FSM returns to IDLE.
- Change `m_addr` during ACCESS, then assert `rstn=0` mid-transfer → `proto_err=1` and held until the reset; reset clears `proto_err`, `s_sel` and `m_ready` asynchronously.
- Back-to-back transfers to slaves 0 then 1 → second SETUP directly follows the first ACCESS with no IDLE cycle.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB fan-out block and its address decoder.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DECERR = 2'd3
    } apb_state_e;

    localparam int APB_PROT_W = 3;

    // Slave-index width; a single slave still gets one index bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decode: region index plus a flag saying whether the
// address falls inside the populated slave map.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter int REGION_LSB = 12,
    parameter int IDX_W      = idx_width(NUM_SLAVES)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [IDX_W-1:0]      idx,
    output logic                  mapped
);

    logic [ADDR_WIDTH-1:0] upper_s;

    // Any bit set above the index field, or an index past the last slave, is unmapped.
    always_comb begin
        idx     = addr[REGION_LSB +: IDX_W];
        upper_s = addr >> (REGION_LSB + IDX_W);
        mapped  = (upper_s == {ADDR_WIDTH{1'b0}}) && (32'(idx) < 32'(NUM_SLAVES));
    end

endmodule

// File: rtl/apb_slave_mux.sv
// One APB master fanned out to NUM_SLAVES slaves, with decode-error response,
// wait-state timeout and a sticky protocol-violation flag.
module apb_slave_mux
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter int REGION_LSB = 12,
    parameter int TIMEOUT    = 16
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             m_sel,
    input  logic                             m_enable,
    input  logic                             m_write,
    input  logic [ADDR_WIDTH-1:0]            m_addr,
    input  logic [DATA_WIDTH-1:0]            m_wdata,
    input  logic [DATA_WIDTH/8-1:0]          m_strb,
    input  logic [APB_PROT_W-1:0]            m_prot,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic                             m_ready,
    output logic                             m_slverr,
    output logic [NUM_SLAVES-1:0]            s_sel,
    output logic                             s_enable,
    output logic                             s_write,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    output logic [DATA_WIDTH/8-1:0]          s_strb,
    output logic [APB_PROT_W-1:0]            s_prot,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]            s_ready,
    input  logic [NUM_SLAVES-1:0]            s_slverr,
    output logic                             proto_err
);

    localparam int               IDX_W    = idx_width(NUM_SLAVES);
    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  mapped_q, mapped_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  proto_q, proto_d;

    logic [IDX_W-1:0]      dec_idx_s;
    logic                  dec_mapped_s;
    logic [DATA_WIDTH-1:0] sel_rdata_s;
    logic                  sel_ready_s;
    logic                  sel_slverr_s;
    logic                  start_s;
    logic                  changed_s;
    logic                  tmo_s;
    logic                  done_s;
    logic                  load_s;

    apb_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .REGION_LSB (REGION_LSB),
        .IDX_W      (IDX_W)
    ) u_dec (
        .addr   (m_addr),
        .idx    (dec_idx_s),
        .mapped (dec_mapped_s)
    );

    // AND-OR mux of the latched slave's response signals.
    always_comb begin
        sel_rdata_s  = {DATA_WIDTH{1'b0}};
        sel_ready_s  = 1'b0;
        sel_slverr_s = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_rdata_s  = sel_rdata_s |
                           ({DATA_WIDTH{idx_q == IDX_W'(i)}} & s_rdata[i*DATA_WIDTH +: DATA_WIDTH]);
            sel_ready_s  = sel_ready_s  | ((idx_q == IDX_W'(i)) & s_ready[i]);
            sel_slverr_s = sel_slverr_s | ((idx_q == IDX_W'(i)) & s_slverr[i]);
        end
    end

    // Transfer bookkeeping shared by the outputs and the next-state logic.
    always_comb begin
        start_s   = m_sel & ~m_enable;
        changed_s = (m_addr != addr_q) | (m_write != write_q) | (m_wdata != wdata_q);
        tmo_s     = (state_q == ST_ACCESS) & (cnt_q == CNT_LAST) & ~sel_ready_s;
        done_s    = (state_q == ST_ACCESS) & (sel_ready_s | tmo_s);
    end

    // Master response and slave select, decoded straight from the current state.
    always_comb begin
        m_ready  = 1'b0;
        m_slverr = 1'b0;
        m_rdata  = {DATA_WIDTH{1'b0}};
        case (state_q)
            ST_ACCESS: begin
                m_ready  = sel_ready_s | tmo_s;
                m_slverr = (sel_slverr_s & sel_ready_s) | tmo_s;
                m_rdata  = sel_rdata_s;
            end
            ST_DECERR: begin
                m_ready  = 1'b1;
                m_slverr = 1'b1;
            end
            default: begin
                m_ready  = 1'b0;
                m_slverr = 1'b0;
            end
        endcase
        if (((state_q == ST_SETUP) || (state_q == ST_ACCESS)) && mapped_q) begin
            s_sel = NUM_SLAVES'(1) << idx_q;
        end else begin
            s_sel = {NUM_SLAVES{1'b0}};
        end
        s_enable  = (state_q == ST_ACCESS);
        s_write   = m_write;
        s_addr    = m_addr;
        s_wdata   = m_wdata;
        s_strb    = m_strb;
        s_prot    = m_prot;
        proto_err = proto_q;
    end

    // Phase tracking; the completing cycle may already carry the next SETUP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_s  = 1'b0;
        proto_d = proto_q | (m_enable & ~m_sel);
        case (state_q)
            ST_IDLE: begin
                proto_d = proto_d | m_enable;
                if (start_s) begin
                    state_d = ST_SETUP;
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                proto_d = proto_d | changed_s;
                if (m_enable) begin
                    state_d = mapped_q ? ST_ACCESS : ST_DECERR;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_ACCESS: begin
                if (done_s) begin
                    state_d = start_s ? ST_SETUP : ST_IDLE;
                    load_s  = start_s;
                end else if (!m_sel) begin
                    state_d = ST_IDLE;
                    proto_d = 1'b1;
                end else begin
                    proto_d = proto_d | changed_s;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_DECERR: begin
                state_d = start_s ? ST_SETUP : ST_IDLE;
                load_s  = start_s;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        idx_d    = load_s ? dec_idx_s    : idx_q;
        mapped_d = load_s ? dec_mapped_s : mapped_q;
        addr_d   = load_s ? m_addr       : addr_q;
        write_d  = load_s ? m_write      : write_q;
        wdata_d  = load_s ? m_wdata      : wdata_q;
    end

    // State registers; reset drops every select immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            idx_q    <= {IDX_W{1'b0}};
            mapped_q <= 1'b0;
            addr_q   <= {ADDR_WIDTH{1'b0}};
            write_q  <= 1'b0;
            wdata_q  <= {DATA_WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            proto_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mapped_q <= mapped_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            proto_q  <= proto_d;
        end
    end

endmodule
